// File: rtl/word_detect_arbiter.sv
// Round-robin arbiter that lends one serial A/B/C sequence detector to N requesters.
// Each granted word is shifted through MSB-first, and its hit count is reported with a done strobe.
//   state  | meaning
//   IDLE   | wait for any request, grant the round-robin winner
//   SHIFT  | one detector step per cycle, DW cycles
//   DONE   | done strobe, done_id/hit_count valid
module word_detect_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                      ck,
  input  logic                      reset,
  input  logic [N-1:0]              req,
  input  logic [N*DW-1:0]           data,
  output logic [N-1:0]              gnt,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N)-1:0]      done_id,
  output logic [$clog2(DW+1)-1:0]   hit_count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(DW);
  localparam int HW = $clog2(DW+1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_DONE  = 3'b100
  } state_t;

  typedef enum logic [2:0] {
    DET_A = 3'b001,
    DET_B = 3'b010,
    DET_C = 3'b100
  } det_t;

  state_t          state_q, state_d;
  det_t            det_q, det_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hit_q, hit_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   cur_id_q, cur_id_d;
  logic [IW-1:0]   done_id_q, done_id_d;
  logic [N-1:0]    gnt_q, gnt_d;

  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   scan_idx;
  logic            x;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % N);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    ptr_d     = ptr_q;
    cur_id_d  = cur_id_q;
    done_id_d = done_id_q;
    gnt_d     = '0;
    x         = shreg_q[DW-1];
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          shreg_d  = data[int'(win_id)*DW +: DW];
          gnt_d    = N'(1) << win_id;
          cur_id_d = win_id;
          ptr_d    = (win_id == IW'(N-1)) ? '0 : win_id + 1'b1;
          cnt_d    = '0;
          hit_d    = '0;
          det_d    = DET_A;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        case (det_q)
          DET_A:   det_d = x ? DET_B : DET_A;
          DET_B:   det_d = x ? DET_C : DET_A;
          DET_C:   det_d = x ? DET_C : DET_B;
          default: det_d = DET_A;
        endcase
        if (det_q == DET_C && x) hit_d = hit_q + 1'b1;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DW-1)) begin
          state_d   = ST_DONE;
          done_id_d = cur_id_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        det_d   = DET_A;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      det_q     <= DET_A;
      shreg_q   <= '0;
      cnt_q     <= '0;
      hit_q     <= '0;
      ptr_q     <= '0;
      cur_id_q  <= '0;
      done_id_q <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      ptr_q     <= ptr_d;
      cur_id_q  <= cur_id_d;
      done_id_q <= done_id_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign done_id   = done_id_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_word_detect_arbiter.sv
// Randomized scoreboard bench for word_detect_arbiter: a cycle-level requester/arbiter model
// pushes expected grants and completions; a negedge monitor pops and compares.
module tb_word_detect_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(DW+1);

  logic              ck = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   data = '0;
  logic [N-1:0]      gnt;
  logic              busy;
  logic              done;
  logic [IW-1:0]     done_id;
  logic [HW-1:0]     hit_count;

  always #5 ck = ~ck;

  word_detect_arbiter #(.N(N), .DW(DW)) dut (
    .ck(ck), .reset(reset), .req(req), .data(data),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .hit_count(hit_count)
  );

  typedef struct { int id; int cyc; int hits; } exp_t;
  exp_t gq[$];
  exp_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_run = 0;
  int m_wait = 0;
  int m_ptr = 0;
  bit rnd_en = 1'b0;
  logic [N-1:0]    req_v = '0, keep = '0, nodrop = '0, raise_next = '0, drop_now = '0;
  logic [N*DW-1:0] data_v = '0;

  always @(posedge ck) cyc++;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Detector as a transition table: states 0=A,1=B,2=C; a hit is a 1 seen while in C.
  function automatic int hits_of(logic [DW-1:0] w);
    int nxt1[3] = '{1, 2, 2};
    int nxt0[3] = '{0, 0, 1};
    int st = 0;
    int h = 0;
    for (int j = DW-1; j >= 0; j--) begin
      if (w[j]) begin
        if (st == 2) h++;
        st = nxt1[st];
      end else begin
        st = nxt0[st];
      end
    end
    return h;
  endfunction

  always @(negedge ck) begin : mon
    exp_t e;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (gnt != '0) begin
        if (gq.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
        else begin
          e = gq.pop_front();
          chk("gnt_onehot", int'(gnt), 1 << e.id);
          chk("gnt_cycle", cyc, e.cyc);
        end
        chk("busy_at_gnt", int'(busy), 1);
      end else if (gq.size() > 0 && gq[0].cyc < cyc) begin
        e = gq.pop_front();
        chk("gnt_missing", 0, 1 << e.id);
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = dq.pop_front();
          chk("done_id", int'(done_id), e.id);
          chk("hit_count", int'(hit_count), e.hits);
          chk("done_cycle", cyc, e.cyc);
        end
        chk("done_with_gnt", int'(gnt), 0);
      end else if (dq.size() > 0 && dq[0].cyc < cyc) begin
        e = dq.pop_front();
        chk("done_missing", 0, 1);
      end
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        chk("busy_len", busy_run, DW+1);
        busy_run = 0;
      end
    end
  end

  task automatic raise(int i, logic [DW-1:0] w);
    req_v[i] = 1'b1;
    data_v[i*DW +: DW] = w;
  endtask

  // One cycle of requester behaviour plus the arbiter model; inputs driven just after negedge.
  task automatic step();
    logic [N-1:0] rn;
    logic [N-1:0] dropped;
    exp_t e;
    int w;
    int idx;
    @(negedge ck); #1;
    rn = raise_next;
    raise_next = '0;
    dropped = '0;
    for (int i = 0; i < N; i++)
      if (rn[i]) raise(i, DW'($urandom));
    for (int i = 0; i < N; i++) begin
      if (drop_now[i] && !nodrop[i]) begin
        req_v[i] = 1'b0;
        dropped[i] = 1'b1;
        if (keep[i]) raise_next[i] = 1'b1;
      end
    end
    drop_now = '0;
    if (rnd_en)
      for (int i = 0; i < N; i++)
        if (!req_v[i] && !dropped[i] && !raise_next[i] && $urandom_range(0, 9) == 0)
          raise(i, DW'($urandom));
    if (m_wait > 0) m_wait--;
    else if (req_v != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && req_v[idx]) w = idx;
      end
      e.id = w; e.cyc = cyc + 1; e.hits = 0;
      gq.push_back(e);
      e.cyc = cyc + 1 + DW; e.hits = hits_of(data_v[w*DW +: DW]);
      dq.push_back(e);
      m_ptr = (w + 1) % N;
      m_wait = DW + 1;
      drop_now[w] = 1'b1;
    end
    req = req_v;
    data = data_v;
  endtask

  task automatic do_reset();
    @(negedge ck); #1;
    reset = 1'b1;
    req_v = '0; keep = '0; nodrop = '0; raise_next = '0; drop_now = '0;
    req = '0;
    gq.delete();
    dq.delete();
    m_wait = 0;
    m_ptr = 0;
    @(negedge ck); #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    raise(0, 8'hFF); repeat (DW+4) step();
    raise(2, 8'hDB); repeat (DW+4) step();
    raise(2, 8'hAA); repeat (DW+4) step();
    raise(2, 8'h00); repeat (DW+4) step();

    do_reset();
    keep = '1;
    for (int i = 0; i < N; i++) raise(i, DW'($urandom));
    repeat (5*(DW+2)) step();
    keep = '0;
    repeat (N*(DW+2)+4) step();

    do_reset();
    raise(3, DW'($urandom)); repeat (DW+4) step();
    raise(0, DW'($urandom)); raise(3, DW'($urandom));
    repeat (2*(DW+2)+4) step();

    raise(1, 8'hFF); step();
    repeat (4) step();
    do_reset();
    raise(2, 8'h7E); repeat (DW+4) step();

    nodrop[1] = 1'b1;
    raise(1, 8'hB7);
    repeat (2*(DW+2)+3) step();
    nodrop = '0;
    req_v[1] = 1'b0;
    repeat (DW+4) step();

    rnd_en = 1'b1;
    repeat (800) step();
    rnd_en = 1'b0;
    repeat (N*(DW+2)+DW+4) step();

    chk("gnt_queue_drained", gq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/word_detect_arbiter.md
# word_detect_arbiter

Round-robin scheduler that shares one serial sequence-detector datapath (one-hot A/B/C Mealy detector, hit = state C with input 1) among N requesters. It grants one requester at a time, captures its DW-bit word, shifts it MSB-first through the detector, and reports the number of hits with a one-cycle completion strobe. It sits between the word-producing client blocks and the shared detector logic, which is instantiated inside this block.

## Interface
- N, 4: number of requesters (2..8).
- DW, 8: word width in bits (2..32).
- ck  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request per requester; bit i high means data[i*DW +: DW] is valid and held stable.
- data  input  N*DW  packed words; requester i at [i*DW +: DW].
- gnt  output  N  one-hot, registered, high for exactly one cycle when requester i's word is captured.
- busy  output  1  high from the gnt cycle through the done cycle inclusive.
- done  output  1  one-cycle strobe; hit_count and done_id valid in that cycle.
- done_id  output  $clog2(N)  index of the requester whose word just finished.
- hit_count  output  $clog2(DW+1)  hits counted for that word.

## Operation
- States: IDLE, SHIFT, DONE (one-hot encoded).
- IDLE: if |req, select winner by round-robin starting at ptr (ptr, ptr+1, ... mod N, first set bit wins); at the edge load shift register with winner's word, gnt <= one-hot(winner), cur_id <= winner, ptr <= (winner+1) mod N, bit counter <= 0, hit_count <= 0, detector <= A, go to SHIFT. If req==0, stay.
- SHIFT: each cycle x = shift_reg[DW-1]; detector: A: x?B:A; B: x?C:A; C: x?C:B. Hit when state==C and x==1; hit_count increments on hit. Shift left by 1, counter++. After DW bits (counter==DW-1 at edge), go to DONE.
- DONE: done=1, done_id=cur_id, hit_count final; next state IDLE.
- req is not sampled in SHIFT or DONE; requesters drop req in the cycle gnt[i] is high. A req still high when IDLE is re-entered is a new request.
- hit_count and done_id hold their values after DONE until the next grant clears hit_count.
- Unused/illegal state encoding recovers to IDLE with detector at A.
- Detector state is reset to A at every grant; no history carries across words.

## Timing
- Reset (sampled high at an edge): state IDLE, ptr=0, detector A, gnt=0, busy=0, done=0, done_id=0, hit_count=0, shift register 0. Reset overrides everything, including mid-SHIFT; the aborted word produces no done.
- req sampled high at edge k (IDLE) → gnt and busy high in cycle k+1; first bit evaluated in cycle k+1; done high in cycle k+1+DW; IDLE in cycle k+2+DW; next gnt earliest cycle k+3+DW.
- Throughput: one word per DW+2 cycles under continuous requests.
- Simultaneous requests: only the round-robin winner is granted; losers wait, req held.
- ptr wraps N-1 → 0.

## Test plan
- Reset, then req=4'b0001, data[7:0]=8'hFF → gnt=0001 one cycle, done 8 cycles later with done_id=0, hit_count=6.
- Single requester 2, word 8'hDB → hit_count=2, done_id=2; word 8'hAA → hit_count=0; word 8'h00 → hit_count=0.
- req=4'b1111 held by re-raising after each gnt → grant order 0,1,2,3,0; each gnt exactly one cycle, spacing 10 cycles (DW=8).
- After grant to 3, req=4'b1001 → next grant 0 (ptr wrap), then 3.
- reset asserted 4 cycles into SHIFT → next cycle all outputs 0, no done; subsequent req=4'b0100 granted cleanly with correct hit_count.
- req held continuously through a word → busy stays high DW+1 cycles, no second gnt until IDLE re-entered; done never coincides with gnt.
